// File: rtl/ring_idx_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : ring_idx_alloc
//  Purpose  : Head/tail allocator for flip-bit ring tags ({flip,idx}).
//             Grants up to ALLOC_WIDTH consecutive tags per cycle, retires up
//             to COMMIT_WIDTH tags per cycle, and rolls the tail back on
//             squash. Holds pointers only; no payload storage.
//  Options  : RING_ALLOC_PERF_EN adds saturating stall / grant counters.
//  Revision : 1.0  initial release
// ============================================================================
module ring_idx_alloc #(
    parameter int SIZE         = 128,
    parameter int ALLOC_WIDTH  = 4,
    parameter int COMMIT_WIDTH = 4
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [ALLOC_WIDTH-1:0]                           i_alloc_req,
    output logic                                             o_alloc_rdy,
    output logic [ALLOC_WIDTH*($clog2(SIZE)+1)-1:0]          o_alloc_idx,
    input  logic [$clog2(COMMIT_WIDTH+1)-1:0]                i_commit_num,
    input  logic                                             i_squash,
    input  logic [$clog2(SIZE):0]                            i_squash_idx,
    output logic [$clog2(SIZE):0]                            o_head,
    output logic [$clog2(SIZE):0]                            o_tail,
    output logic [$clog2(SIZE):0]                            o_count,
    output logic                                             o_empty,
`ifdef RING_ALLOC_PERF_EN
    output logic [31:0]                                      o_perf_full_stall,
    output logic [31:0]                                      o_perf_alloc_cnt,
`endif
    output logic                                             o_full
);

    localparam int c_idxw = $clog2(SIZE);
    localparam int c_tw   = c_idxw + 1;

    localparam logic [c_tw-1:0] c_size  = c_tw'(SIZE);
    localparam logic [c_tw-1:0] c_awidth = c_tw'(ALLOC_WIDTH);

    logic [c_tw-1:0] r_head;
    logic [c_tw-1:0] r_tail;

    logic [c_tw-1:0] w_count;
    logic [c_tw-1:0] w_free;
    logic [c_tw-1:0] w_alloc_num;
    logic [c_tw-1:0] w_commit_ext;
    logic [c_tw-1:0] w_sq_dist;
    logic            w_alloc_fire;

    // Occupancy and readiness derive only from the registered pointers; the
    // power-of-2 depth makes the flip bit fall out of a plain subtract.
    always_comb begin
        w_count      = r_tail - r_head;
        w_free       = c_size - w_count;
        w_commit_ext = c_tw'(i_commit_num);
        w_sq_dist    = i_squash_idx - r_head;
    end

    // Number of tags requested this cycle (request mask is prefix form).
    always_comb begin
        w_alloc_num = '0;
        for (int k = 0; k < ALLOC_WIDTH; k++) begin
            w_alloc_num = w_alloc_num + c_tw'(i_alloc_req[k]);
        end
    end

    assign o_alloc_rdy  = (w_free >= c_awidth);
    assign w_alloc_fire = (|i_alloc_req) && o_alloc_rdy && !i_squash;

    assign o_head  = r_head;
    assign o_tail  = r_tail;
    assign o_count = w_count;
    assign o_empty = (w_count == '0);
    assign o_full  = (w_count == c_size);

    generate
        for (genvar k = 0; k < ALLOC_WIDTH; k++) begin : g_slot
            assign o_alloc_idx[k*c_tw +: c_tw] = r_tail + c_tw'(k);
        end
    endgenerate

    // Pointer update: commit always advances head; squash overrides any
    // allocation and moves tail straight to the first discarded tag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            r_head <= r_head + w_commit_ext;
            if (i_squash) begin
                r_tail <= i_squash_idx;
            end else if (w_alloc_fire) begin
                r_tail <= r_tail + w_alloc_num;
            end
        end
    end

`ifdef RING_ALLOC_PERF_EN
    logic [31:0] r_perf_full_stall;
    logic [31:0] r_perf_alloc_cnt;
    logic [32:0] w_alloc_sum;

    assign w_alloc_sum = {1'b0, r_perf_alloc_cnt} + 33'(w_alloc_num);

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_full_stall <= '0;
            r_perf_alloc_cnt  <= '0;
        end else begin
            if ((|i_alloc_req) && !o_alloc_rdy && !i_squash && (r_perf_full_stall != '1)) begin
                r_perf_full_stall <= r_perf_full_stall + 32'd1;
            end
            if (w_alloc_fire) begin
                r_perf_alloc_cnt <= w_alloc_sum[32] ? '1 : w_alloc_sum[31:0];
            end
        end
    end

    assign o_perf_full_stall = r_perf_full_stall;
    assign o_perf_alloc_cnt  = r_perf_alloc_cnt;
`endif

    // Retiring more than is live corrupts the ring.
    a_commit_legal : assert property (@(posedge clk) disable iff (rst)
        w_commit_ext <= w_count);

    // Squash target must lie between the post-commit head and the tail.
    a_squash_legal : assert property (@(posedge clk) disable iff (rst)
        i_squash |-> ((w_sq_dist >= w_commit_ext) && (w_sq_dist <= w_count)));

endmodule
`default_nettype wire

// File: tb/tb_ring_idx_alloc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ring_idx_alloc
//  Purpose  : Self-checking bench for ring_idx_alloc (table vectors, directed
//             corner sequences, randomized traffic vs. reference model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_ring_idx_alloc;

    localparam int SIZE = 128;
    localparam int AW   = 4;
    localparam int CW   = 4;
    localparam int TW   = $clog2(SIZE) + 1;
    localparam int CNW  = $clog2(CW + 1);
    localparam int MOD  = 2 * SIZE;

    logic                clk;
    logic                rst;
    logic [AW-1:0]       alloc_req;
    logic                alloc_rdy;
    logic [AW*TW-1:0]    alloc_idx;
    logic [CNW-1:0]      commit_num;
    logic                squash;
    logic [TW-1:0]       squash_idx;
    logic [TW-1:0]       head;
    logic [TW-1:0]       tail;
    logic [TW-1:0]       count;
    logic                empty;
    logic                full;
`ifdef RING_ALLOC_PERF_EN
    logic [31:0]         perf_full_stall;
    logic [31:0]         perf_alloc_cnt;
`endif

    ring_idx_alloc #(.SIZE(SIZE), .ALLOC_WIDTH(AW), .COMMIT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_alloc_req  (alloc_req),
        .o_alloc_rdy  (alloc_rdy),
        .o_alloc_idx  (alloc_idx),
        .i_commit_num (commit_num),
        .i_squash     (squash),
        .i_squash_idx (squash_idx),
        .o_head       (head),
        .o_tail       (tail),
        .o_count      (count),
        .o_empty      (empty),
`ifdef RING_ALLOC_PERF_EN
        .o_perf_full_stall (perf_full_stall),
        .o_perf_alloc_cnt  (perf_alloc_cnt),
`endif
        .o_full       (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: absolute (never wrapping) positions of head and tail;
    // tags are these positions modulo twice the ring depth.
    longint m_h = 0;
    longint m_t = 0;
    longint m_stall = 0;
    longint m_granted = 0;

    function automatic logic [TW-1:0] tag_of(input longint pos);
        return TW'(pos % MOD);
    endfunction

    function automatic int m_cnt();
        return int'(m_t - m_h);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic [AW-1:0] req,
                                input logic [CNW-1:0] cm, input logic sq,
                                input logic [TW-1:0] sqi);
        int  pop;
        bit  rdy;
        longint old_h;
        if (r) begin
            m_h = 0; m_t = 0; m_stall = 0; m_granted = 0;
        end else begin
            pop = $countones(req);
            rdy = (SIZE - m_cnt()) >= AW;
            old_h = m_h;
            if (req != 0 && !rdy && !sq) m_stall++;
            m_h = m_h + cm;
            if (sq) begin
                m_t = old_h + ((int'(sqi) - int'(old_h % MOD) + MOD) % MOD);
            end else if (req != 0 && rdy) begin
                m_t = m_t + pop;
                m_granted = m_granted + pop;
            end
        end
    endtask

    task automatic check_all();
        chk("head",  head,  tag_of(m_h));
        chk("tail",  tail,  tag_of(m_t));
        chk("count", count, m_cnt());
        chk("empty", empty, m_cnt() == 0);
        chk("full",  full,  m_cnt() == SIZE);
        chk("rdy",   alloc_rdy, (SIZE - m_cnt()) >= AW);
        for (int k = 0; k < AW; k++) begin
            chk("alloc_idx", alloc_idx[k*TW +: TW], tag_of(m_t + k));
        end
`ifdef RING_ALLOC_PERF_EN
        chk("perf_stall", perf_full_stall, m_stall);
        chk("perf_alloc", perf_alloc_cnt,  m_granted);
`endif
    endtask

    task automatic step(input logic r, input logic [AW-1:0] req,
                        input logic [CNW-1:0] cm, input logic sq,
                        input logic [TW-1:0] sqi);
        rst = r; alloc_req = req; commit_num = cm; squash = sq; squash_idx = sqi;
        @(posedge clk);
        model_update(r, req, cm, sq, sqi);
        #1;
        check_all();
    endtask

    // Walk head and tail together up to an absolute position (from a small one).
    task automatic drive_to(input longint tgt);
        int  na;
        int  nc;
        for (int i = 0; i < 200 && !(m_h == tgt && m_t == tgt); i++) begin
            na = (tgt - m_t) < AW ? int'(tgt - m_t) : AW;
            nc = m_cnt() < CW ? m_cnt() : CW;
            step(1'b0, AW'((1 << na) - 1), CNW'(nc), 1'b0, '0);
        end
        chk("drive_to_head", head, tag_of(tgt));
        chk("drive_to_tail", tail, tag_of(tgt));
    endtask

    typedef struct {
        logic           rst;
        logic [AW-1:0]  req;
        logic [CNW-1:0] cm;
        logic           sq;
        logic [TW-1:0]  sqi;
        logic [TW-1:0]  e_head;
        logic [TW-1:0]  e_tail;
        logic [TW-1:0]  e_count;
        logic           e_rdy;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [31:0] perf_before;
        int          nreq;
        int          cmax;
        int          cm;
        int          d;
        logic        sq;
        logic        r;

        perf_before = '0;
        tbl[0] = '{1'b1, 4'h0, 3'd0, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1};
        tbl[1] = '{1'b0, 4'hF, 3'd0, 1'b0, 8'd0, 8'd0, 8'd4, 8'd4, 1'b1};
        tbl[2] = '{1'b0, 4'h3, 3'd2, 1'b0, 8'd0, 8'd2, 8'd6, 8'd4, 1'b1};
        tbl[3] = '{1'b0, 4'h0, 3'd4, 1'b0, 8'd0, 8'd6, 8'd6, 8'd0, 1'b1};
        tbl[4] = '{1'b0, 4'h1, 3'd0, 1'b0, 8'd0, 8'd6, 8'd7, 8'd1, 1'b1};
        tbl[5] = '{1'b0, 4'hF, 3'd0, 1'b1, 8'd6, 8'd6, 8'd6, 8'd0, 1'b1};
        tbl[6] = '{1'b0, 4'h7, 3'd0, 1'b0, 8'd0, 8'd6, 8'd9, 8'd3, 1'b1};
        tbl[7] = '{1'b0, 4'hF, 3'd0, 1'b1, 8'd9, 8'd6, 8'd9, 8'd3, 1'b1};
        tbl[8] = '{1'b0, 4'h0, 3'd3, 1'b1, 8'd9, 8'd9, 8'd9, 8'd0, 1'b1};
        tbl[9] = '{1'b1, 4'hF, 3'd1, 1'b1, 8'd5, 8'd0, 8'd0, 8'd0, 1'b1};

        rst = 1'b1; alloc_req = '0; commit_num = '0; squash = 1'b0; squash_idx = '0;

        // Reset with no stimulus.
        step(1'b1, '0, '0, 1'b0, '0);
        chk("t1_empty", empty, 1);
        chk("t1_rdy",   alloc_rdy, 1);
        for (int k = 0; k < AW; k++) chk("t1_slot", alloc_idx[k*TW +: TW], k);

        // Fill the ring, then one more request must stall.
        for (int i = 0; i < 32; i++) step(1'b0, 4'hF, '0, 1'b0, '0);
        chk("t2_tail", tail, 8'h80);
        chk("t2_full", full, 1);
        chk("t2_rdy",  alloc_rdy, 0);
        step(1'b0, 4'hF, '0, 1'b0, '0);
        chk("t2_hold", tail, 8'h80);
`ifdef RING_ALLOC_PERF_EN
        chk("t2_stall", perf_full_stall, 1);
`endif

        // Commit from full: freed slots only visible a cycle later.
        chk("t3_rdy_pre", alloc_rdy, 0);
        step(1'b0, 4'h3, 3'd4, 1'b0, '0);
        chk("t3_count", count, 124);
        chk("t3_rdy",   alloc_rdy, 1);
        chk("t3_tail",  tail, 8'h80);

        // Table vectors.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].cm, tbl[i].sq, tbl[i].sqi);
            chk("tbl_head",  head,  tbl[i].e_head);
            chk("tbl_tail",  tail,  tbl[i].e_tail);
            chk("tbl_count", count, tbl[i].e_count);
            chk("tbl_rdy",   alloc_rdy, tbl[i].e_rdy);
        end

        // Wrap at the top of the index space.
        drive_to(126);
        chk("t4_s0", alloc_idx[0*TW +: TW], 8'd126);
        chk("t4_s1", alloc_idx[1*TW +: TW], 8'd127);
        chk("t4_s2", alloc_idx[2*TW +: TW], 8'h80);
        chk("t4_s3", alloc_idx[3*TW +: TW], 8'h81);
        step(1'b0, 4'hF, '0, 1'b0, '0);
        chk("t4_tail", tail, 8'h82);

        // Squash with same-cycle commit and request.
        step(1'b1, '0, '0, 1'b0, '0);
        drive_to(10);
        for (int i = 0; i < 7; i++) step(1'b0, 4'hF, '0, 1'b0, '0);
        step(1'b0, 4'h3, '0, 1'b0, '0);
        chk("t5_tail_pre", tail, 40);
`ifdef RING_ALLOC_PERF_EN
        perf_before = perf_alloc_cnt;
`endif
        step(1'b0, 4'hF, 3'd2, 1'b1, 8'd30);
        chk("t5_tail", tail, 30);
        chk("t5_head", head, 12);
`ifdef RING_ALLOC_PERF_EN
        chk("t5_perf", perf_alloc_cnt, perf_before);
`endif

        // Reset wins over a concurrent squash.
        step(1'b1, 4'hF, 3'd3, 1'b1, 8'd20);
        chk("t6_head",  head, 0);
        chk("t6_tail",  tail, 0);
        chk("t6_empty", empty, 1);

        // Randomized legal traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            nreq = $urandom_range(0, AW);
            cmax = (i < 1500) ? 1 : CW;
            if (m_cnt() < cmax) cmax = m_cnt();
            cm = $urandom_range(0, cmax);
            sq = ($urandom_range(0, 7) == 0);
            d  = $urandom_range(cm, m_cnt());
            r  = ($urandom_range(0, 299) == 0);
            step(r, AW'((1 << nreq) - 1), CNW'(cm), sq, tag_of(m_h + d));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
